// File: rtl/lcd_text_buffer_pkg.sv
// Shared definitions for the LCD text buffer: command codes, fill character, geometry defaults, FSM states.
// LCD_TEXT_BUF_SCROLL_EN adds the SCROLL state to the state encoding.
package lcd_pkg;

    localparam int DEF_COLS = 16;
    localparam int DEF_ROWS = 2;
    localparam logic [7:0] BLANK_CHAR = 8'h20;

    typedef enum logic [1:0] {
        CMD_CHAR   = 2'b00,
        CMD_SETCUR = 2'b01,
        CMD_CLEAR  = 2'b10,
        CMD_HOME   = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        ST_CLEAR_INIT,
        ST_IDLE,
        ST_CLEAR
`ifdef LCD_TEXT_BUF_SCROLL_EN
        , ST_SCROLL
`endif
    } state_e;

endpackage

// File: rtl/lcd_text_buffer_if.sv
// Host command channel of the LCD text buffer: valid/ready handshake carrying command, character and cursor target.
interface lcd_text_buffer_if #(
    parameter int ADDR_W = 5
);
    logic              wr_valid;
    logic              wr_ready;
    logic [1:0]        wr_cmd;
    logic [7:0]        wr_char;
    logic [ADDR_W-1:0] wr_addr;

    modport master (
        output wr_valid,
        output wr_cmd,
        output wr_char,
        output wr_addr,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_cmd,
        input  wr_char,
        input  wr_addr,
        output wr_ready
    );
endinterface

// File: rtl/lcd_buf_ram.sv
// Character cell array: one write port, one registered read port for refresh, one combinational read port for scrolling.
module lcd_buf_ram
    import lcd_pkg::*;
#(
    parameter int         DEPTH  = 32,
    parameter int         ADDR_W = 5,
    parameter logic [7:0] BLANK  = BLANK_CHAR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata,
    input  logic [ADDR_W-1:0] caddr,
    output logic [7:0]        cdata
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH);

    logic [7:0] mem [DEPTH];
    logic       w_ok;
    logic       r_ok;
    logic       c_ok;

    // Addresses beyond the array are ignored on write and read back as BLANK.
    assign w_ok = {1'b0, waddr} < DEPTH_EXT;
    assign r_ok = {1'b0, raddr} < DEPTH_EXT;
    assign c_ok = {1'b0, caddr} < DEPTH_EXT;

    always_ff @(posedge clk) begin
        if (we && w_ok) begin
            mem[waddr[IDX_W-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else begin
            rdata <= r_ok ? mem[raddr[IDX_W-1:0]] : BLANK;
        end
    end

    assign cdata = c_ok ? mem[caddr[IDX_W-1:0]] : BLANK;

endmodule

// File: rtl/lcd_text_buffer.sv
// LCD character buffer: command FSM, cursor, clear/scroll sweep and dirty tracking around lcd_buf_ram.
// Optional: LCD_TEXT_BUF_SCROLL_EN makes a write past the last cell scroll up instead of wrapping.
module lcd_text_buffer
    import lcd_pkg::*;
#(
    parameter int         COLS   = DEF_COLS,
    parameter int         ROWS   = DEF_ROWS,
    parameter int         ADDR_W = 5,
    parameter logic [7:0] BLANK  = BLANK_CHAR
) (
    input  logic              clk,
    input  logic              rst,
    lcd_text_buffer_if.slave  host,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    input  logic              refresh_done,
    output logic              dirty,
    output logic              busy,
    output logic [ADDR_W-1:0] cursor
);

    localparam int D = ROWS * COLS;
    localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(D - 1);
    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'((ROWS - 1) * COLS);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(COLS);
    localparam logic [ADDR_W:0]   D_EXT    = (ADDR_W+1)'(D);

    state_e            state, state_nx;
    logic [ADDR_W-1:0] sweep, sweep_nx;
    logic [ADDR_W-1:0] cursor_nx;
    logic              dirty_nx;
    logic              ready_q;
    logic              accept;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [7:0]        ram_wdata;
    logic [ADDR_W-1:0] copy_addr;
    logic [7:0]        copy_data;
    logic              copy_sel;

    assign host.wr_ready = ready_q;
    assign accept        = host.wr_valid && ready_q;
    assign copy_addr     = sweep + ROW_STEP;

`ifdef LCD_TEXT_BUF_SCROLL_EN
    assign copy_sel = (state == ST_SCROLL) && (sweep < LAST_ROW);
`else
    assign copy_sel = 1'b0;
`endif

    lcd_buf_ram #(
        .DEPTH  (D),
        .ADDR_W (ADDR_W),
        .BLANK  (BLANK)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (rd_addr),
        .rdata (rd_data),
        .caddr (copy_addr),
        .cdata (copy_data)
    );

    // Every non-idle state is a one-cell-per-cycle sweep over the whole array.
    always_comb begin
        state_nx  = state;
        sweep_nx  = sweep;
        cursor_nx = cursor;
        ram_we    = 1'b0;
        ram_waddr = cursor;
        ram_wdata = host.wr_char;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    case (host.wr_cmd)
                        CMD_CHAR: begin
                            ram_we = 1'b1;
`ifdef LCD_TEXT_BUF_SCROLL_EN
                            if (cursor == LAST) begin
                                state_nx = ST_SCROLL;
                            end else begin
                                cursor_nx = cursor + 1'b1;
                            end
`else
                            cursor_nx = (cursor == LAST) ? '0 : cursor + 1'b1;
`endif
                        end
                        CMD_SETCUR: begin
                            cursor_nx = ({1'b0, host.wr_addr} >= D_EXT) ? LAST : host.wr_addr;
                        end
                        CMD_CLEAR: begin
                            state_nx = ST_CLEAR;
                        end
                        default: begin
                            cursor_nx = '0;
                        end
                    endcase
                end
            end
            default: begin
                ram_we    = 1'b1;
                ram_waddr = sweep;
                ram_wdata = copy_sel ? copy_data : BLANK;
                if (sweep == LAST) begin
                    sweep_nx = '0;
                    state_nx = ST_IDLE;
`ifdef LCD_TEXT_BUF_SCROLL_EN
                    cursor_nx = (state == ST_SCROLL) ? LAST_ROW : '0;
`else
                    cursor_nx = '0;
`endif
                end else begin
                    sweep_nx = sweep + 1'b1;
                end
            end
        endcase
        // A cell write in the same cycle as refresh_done keeps the buffer dirty.
        dirty_nx = ram_we ? 1'b1 : (refresh_done ? 1'b0 : dirty);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_CLEAR_INIT;
            sweep   <= '0;
            cursor  <= '0;
            dirty   <= 1'b1;
            busy    <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state   <= state_nx;
            sweep   <= sweep_nx;
            cursor  <= cursor_nx;
            dirty   <= dirty_nx;
            busy    <= (state_nx != ST_IDLE);
            ready_q <= (state_nx == ST_IDLE);
        end
    end

endmodule
